stream_demux: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake and packet-level channel locking. It generalises the combinational 8-way demux to any channel count and data width. Each output has a one-entry register slot, so the outputs are registered and back-pressure is honoured per channel. It sits between a bus master and multiple peripheral stream sinks in the MCU.

---
 rtl/stream_demux_pkg.sv | 16 +
 rtl/stream_demux_slot.sv | 34 +++
 rtl/stream_demux.sv | 106 ++++++++++
 tb/tb_stream_demux.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types, constants and helpers for the stream_demux block.
package stream_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DROP_CNT_W = 16;

  // Non-power-of-two channel counts leave select codes with no slot behind them.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned channels);
    return sel < channels;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register slot (valid, data, last) with load/drain handshake.
module stream_demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             can_load
);

  assign can_load = !valid || ready;

  // Data and last are left untouched on drain so the payload holds while idle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux with packet-level channel locking.
// Optional drop counter enabled by defining STREAM_DEMUX_DROP_CNT_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Enable,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [WIDTH-1:0]          InData,
  input  logic [SEL_W-1:0]          InSel,
  input  logic                      InLast,
  output logic [CHANNELS-1:0]       OutValid,
  input  logic [CHANNELS-1:0]       OutReady,
  output logic [CHANNELS*WIDTH-1:0] OutData,
  output logic [CHANNELS-1:0]       OutLast,
  output logic                      Busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]     DropCount
`endif
);

  state_t              state;
  logic [SEL_W-1:0]    locked_sel;
  logic [SEL_W-1:0]    target;
  logic                target_ok;
  logic                target_can_load;
  logic                accept;
  logic [CHANNELS-1:0] slot_can_load;
  logic [CHANNELS-1:0] slot_load;

  assign target    = (state == LOCKED) ? locked_sel : InSel;
  assign target_ok = sel_in_range(32'(target), CHANNELS);

  // Decoded compare instead of an index, so unmapped select codes never address past the slots.
  always_comb begin
    target_can_load = 1'b0;
    slot_load       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (target == SEL_W'(c)) begin
        target_can_load = slot_can_load[c];
        slot_load[c]    = accept && target_ok;
      end
    end
  end

  assign InReady = Reset_n && Enable && (!target_ok || target_can_load);
  assign accept  = InValid && InReady;
  assign Busy    = (state == LOCKED);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      locked_sel <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!InLast) begin
            state      <= LOCKED;
            locked_sel <= InSel;
          end
        end
        LOCKED: begin
          if (InLast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    stream_demux_slot #(.WIDTH(WIDTH)) u_slot (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .load      (slot_load[c]),
      .load_data (InData),
      .load_last (InLast),
      .ready     (OutReady[c]),
      .valid     (OutValid[c]),
      .data      (OutData[c*WIDTH +: WIDTH]),
      .last      (OutLast[c]),
      .can_load  (slot_can_load[c])
    );
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      drop_cnt <= '0;
    end else if (accept && !target_ok && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign DropCount = drop_cnt;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: vector table plus hand-written multi-cycle sequences.
module tb_stream_demux;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  // 8-channel instance
  logic        a_en, a_vld, a_rdy, a_last, a_busy;
  logic [31:0] a_data;
  logic [2:0]  a_sel;
  logic [7:0]  a_ov, a_ordy, a_ol;
  logic [255:0] a_od;

  // 6-channel instance for unmapped select codes
  logic        b_en, b_vld, b_rdy, b_last, b_busy;
  logic [31:0] b_data;
  logic [2:0]  b_sel;
  logic [5:0]  b_ov, b_ordy, b_ol;
  logic [191:0] b_od;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] a_drop, b_drop;
`endif

  stream_demux #(.WIDTH(32), .CHANNELS(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(a_en), .InValid(a_vld), .InReady(a_rdy),
    .InData(a_data), .InSel(a_sel), .InLast(a_last), .OutValid(a_ov), .OutReady(a_ordy),
    .OutData(a_od), .OutLast(a_ol), .Busy(a_busy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .DropCount(a_drop)
`endif
  );

  stream_demux #(.WIDTH(32), .CHANNELS(6)) dut6 (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(b_en), .InValid(b_vld), .InReady(b_rdy),
    .InData(b_data), .InSel(b_sel), .InLast(b_last), .OutValid(b_ov), .OutReady(b_ordy),
    .OutData(b_od), .OutLast(b_ol), .Busy(b_busy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .DropCount(b_drop)
`endif
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        en;
    logic        vld;
    logic [2:0]  sel;
    logic [31:0] data;
    logic        last;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_ov;
    logic        exp_busy;
    int          exp_ch;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic vld, input logic [2:0] sel,
                              input logic [31:0] data, input logic last, input logic [7:0] ordy,
                              input logic exp_rdy, input logic [7:0] exp_ov, input logic exp_busy,
                              input int exp_ch, input logic [31:0] exp_data, input logic exp_last);
    vec_t v;
    v.en = en; v.vld = vld; v.sel = sel; v.data = data; v.last = last; v.ordy = ordy;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_busy = exp_busy;
    v.exp_ch = exp_ch; v.exp_data = exp_data; v.exp_last = exp_last;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(1, 1, 3, 32'hA5A5_0003, 1, 8'hFF, 1, 8'h08, 0,  3, 32'hA5A5_0003, 1);
    vecs[1]  = mk(1, 0, 0, 32'h0,         0, 8'hFF, 1, 8'h00, 0,  3, 32'hA5A5_0003, 1);
    vecs[2]  = mk(1, 1, 5, 32'h1,         0, 8'hFF, 1, 8'h20, 1,  5, 32'h1,         0);
    vecs[3]  = mk(1, 1, 2, 32'h2,         0, 8'hFF, 1, 8'h20, 1,  5, 32'h2,         0);
    vecs[4]  = mk(1, 1, 2, 32'h3,         0, 8'hFF, 1, 8'h20, 1,  5, 32'h3,         0);
    vecs[5]  = mk(1, 1, 2, 32'h4,         1, 8'hFF, 1, 8'h20, 0,  5, 32'h4,         1);
    vecs[6]  = mk(1, 0, 0, 32'h0,         0, 8'hFF, 1, 8'h00, 0, -1, 32'h0,         0);
    vecs[7]  = mk(1, 1, 1, 32'h11,        1, 8'hFD, 1, 8'h02, 0,  1, 32'h11,        1);
    vecs[8]  = mk(1, 1, 1, 32'h12,        1, 8'hFD, 0, 8'h02, 0,  1, 32'h11,        1);
    vecs[9]  = mk(1, 1, 6, 32'h16,        1, 8'hFD, 1, 8'h42, 0,  6, 32'h16,        1);
    vecs[10] = mk(1, 1, 1, 32'h12,        1, 8'hFF, 1, 8'h02, 0,  1, 32'h12,        1);
    vecs[11] = mk(1, 0, 0, 32'h0,         0, 8'hFF, 1, 8'h00, 0, -1, 32'h0,         0);
    vecs[12] = mk(0, 1, 4, 32'h44,        0, 8'hFF, 0, 8'h00, 0, -1, 32'h0,         0);

    a_en = 1; a_vld = 0; a_sel = 0; a_data = 0; a_last = 0; a_ordy = 8'hFF;
    b_en = 1; b_vld = 0; b_sel = 0; b_data = 0; b_last = 0; b_ordy = 6'h3F;

    // Reset state while held in reset
    #12;
    chk("rst_out_valid", 64'(a_ov), 64'h0);
    chk("rst_out_data", a_od[63:0], 64'h0);
    chk("rst_out_last", 64'(a_ol), 64'h0);
    chk("rst_in_ready", 64'(a_rdy), 64'h0);
    chk("rst_busy", 64'(a_busy), 64'h0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("rst_drop", 64'(a_drop), 64'h0);
`endif
    Reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(a_rdy), 64'h1);
    next_cycle();

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      a_en = vecs[i].en; a_vld = vecs[i].vld; a_sel = vecs[i].sel;
      a_data = vecs[i].data; a_last = vecs[i].last; a_ordy = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(a_rdy), 64'(vecs[i].exp_rdy));
      next_cycle();
      chk($sformatf("v%0d_out_valid", i), 64'(a_ov), 64'(vecs[i].exp_ov));
      chk($sformatf("v%0d_busy", i), 64'(a_busy), 64'(vecs[i].exp_busy));
      if (vecs[i].exp_ch >= 0) begin
        chk($sformatf("v%0d_out_data", i), 64'(a_od[vecs[i].exp_ch*32 +: 32]), 64'(vecs[i].exp_data));
        chk($sformatf("v%0d_out_last", i), 64'(a_ol[vecs[i].exp_ch]), 64'(vecs[i].exp_last));
      end
    end

    // Full throughput: 16 back-to-back beats on channel 0
    a_en = 1; a_ordy = 8'hFF; a_sel = 0;
    for (int i = 0; i < 16; i++) begin
      a_vld = 1; a_data = 32'h100 + 32'(i); a_last = (i == 15);
      #1;
      chk($sformatf("tp%0d_in_ready", i), 64'(a_rdy), 64'h1);
      next_cycle();
      chk($sformatf("tp%0d_out_valid", i), 64'(a_ov), 64'h01);
      chk($sformatf("tp%0d_out_data", i), 64'(a_od[31:0]), 64'(32'h100 + 32'(i)));
      chk($sformatf("tp%0d_busy", i), 64'(a_busy), 64'(i != 15));
    end
    a_vld = 0;
    next_cycle();
    chk("tp_drained", 64'(a_ov), 64'h0);

    // Reset mid-packet
    a_ordy = 8'h00; a_vld = 1; a_sel = 2; a_data = 32'h77; a_last = 0;
    next_cycle();
    chk("mid_busy", 64'(a_busy), 64'h1);
    chk("mid_out_valid", 64'(a_ov), 64'h04);
    a_vld = 0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(a_ov), 64'h0);
    chk("mid_rst_in_ready", 64'(a_rdy), 64'h0);
    chk("mid_rst_busy", 64'(a_busy), 64'h0);
    chk("mid_rst_out_data", 64'(a_od[95:64]), 64'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    a_ordy = 8'hFF; a_vld = 1; a_sel = 4; a_data = 32'h4444; a_last = 1;
    #1;
    chk("post_rst_in_ready", 64'(a_rdy), 64'h1);
    next_cycle();
    chk("post_rst_out_valid", 64'(a_ov), 64'h10);
    chk("post_rst_out_data", 64'(a_od[4*32 +: 32]), 64'h4444);
    chk("post_rst_busy", 64'(a_busy), 64'h0);
    a_vld = 0;

    // Unmapped select on the 6-channel instance: 3-beat packet discarded
    b_vld = 1; b_sel = 7;
    for (int i = 0; i < 3; i++) begin
      b_data = 32'h700 + 32'(i); b_last = (i == 2);
      if (i > 0) b_sel = 1;
      #1;
      chk($sformatf("oor%0d_in_ready", i), 64'(b_rdy), 64'h1);
      next_cycle();
      chk($sformatf("oor%0d_out_valid", i), 64'(b_ov), 64'h0);
      chk($sformatf("oor%0d_busy", i), 64'(b_busy), 64'(i != 2));
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    chk("oor_drop_count", 64'(b_drop), 64'h3);
`endif
    b_sel = 2; b_data = 32'h222; b_last = 1;
    next_cycle();
    chk("oor_after_out_valid", 64'(b_ov), 64'h04);
    chk("oor_after_out_data", 64'(b_od[2*32 +: 32]), 64'h222);
    b_vld = 0;
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
